// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, IR field layout, state encoding.
// Build option: SINGLE_STEP_EN adds the PAUSE state used for single-stepping.
package cpu_ctrl_pkg;

    localparam int NUM_REGS = 16;
    localparam int OPW      = 5;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    typedef logic [OPW-1:0] opcode_t;
    typedef logic [3:0]     reg_idx_t;

    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110;
    localparam opcode_t OP_ROR  = 5'b00111;
    localparam opcode_t OP_ROL  = 5'b01000;
    localparam opcode_t OP_SHR  = 5'b01001;
    localparam opcode_t OP_SHRA = 5'b01010;
    localparam opcode_t OP_SHL  = 5'b01011;
    localparam opcode_t OP_MUL  = 5'b01111;
    localparam opcode_t OP_DIV  = 5'b10000;
    localparam opcode_t OP_NEG  = 5'b10001;
    localparam opcode_t OP_NOT  = 5'b10010;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T4U, S_T5, S_T6, S_HALT
`ifdef SINGLE_STEP_EN
        , S_PAUSE
`endif
    } seq_state_t;

    typedef struct packed {
        opcode_t  op;
        reg_idx_t ra;
        reg_idx_t rb;
        reg_idx_t rc;
    } ir_fields_t;

    function automatic ir_fields_t decode_ir(input logic [31:0] ir);
        ir_fields_t f;
        f.op = ir[IR_OP_MSB:IR_OP_LSB];
        f.ra = ir[IR_RA_MSB:IR_RA_LSB];
        f.rb = ir[IR_RB_MSB:IR_RB_LSB];
        f.rc = ir[IR_RC_MSB:IR_RC_LSB];
        return f;
    endfunction

    function automatic logic is_unary(input opcode_t op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input opcode_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal(input opcode_t op);
        return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
                           OP_SHRA, OP_SHL, OP_MUL, OP_DIV, OP_NEG, OP_NOT});
    endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Sequencer <-> datapath control bundle; master is the sequencer, slave the datapath.
// Build option: SINGLE_STEP_EN adds the step input.
interface alu_instr_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic                run;
    logic                mem_ready;
    logic [31:0]         ir;
`ifdef SINGLE_STEP_EN
    logic                step;
`endif
    logic                PCout, MARin, incPC, PCin, read, MDRin, MDRout, IRin;
    logic                Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
    logic [NUM_REGS-1:0] Rin;
    logic [NUM_REGS-1:0] Rout;
    opcode_t             opcode;
    logic                busy, done, illegal;

    modport master (
`ifdef SINGLE_STEP_EN
        input  step,
`endif
        input  run, mem_ready, ir,
        output PCout, MARin, incPC, PCin, read, MDRin, MDRout, IRin,
        output Yin, Zin, ZLowOut, ZHighOut, HIin, LOin,
        output Rin, Rout, opcode, busy, done, illegal
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        output step,
`endif
        output run, mem_ready, ir,
        input  PCout, MARin, incPC, PCin, read, MDRin, MDRout, IRin,
        input  Yin, Zin, ZLowOut, ZHighOut, HIin, LOin,
        input  Rin, Rout, opcode, busy, done, illegal
    );

endinterface

// File: rtl/reg_select_decoder.sv
// Register-field to one-hot select; all-zero when not enabled.
module reg_select_decoder #(
    parameter int WIDTH = 16
) (
    input  logic [$clog2(WIDTH)-1:0] sel,
    input  logic                     en,
    output logic [WIDTH-1:0]         onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Moore control unit sequencing fetch/decode/execute/writeback for register-register ALU ops.
// Build option: SINGLE_STEP_EN parks the sequencer in PAUSE after each instruction until step.
module alu_instr_sequencer
    import cpu_ctrl_pkg::*;
(
    input logic            clock,
    input logic            clear,
    alu_instr_sequencer_if.master bus
);

    seq_state_t          state_q, state_d, after_done;
    ir_fields_t          ir_now, ir_q;
    logic                rin_en, rout_en;
    reg_idx_t            rout_sel;
    logic [NUM_REGS-1:0] rin_vec, rout_vec;

    assign ir_now = decode_ir(bus.ir);

    // The datapath IR holds the new instruction from T3 on; capture it as T3 is left.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            // NOTE: ir_q is reset too, so T4..T6 never decode X after a mid-instruction clear.
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            if (state_q == S_T3) ir_q <= ir_now;
        end
    end

    always_comb begin
        // NOTE: every output and next-state gets a default first, so no latch is inferred.
        state_d      = state_q;
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.incPC    = 1'b0;
        bus.PCin     = 1'b0;
        bus.read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.ZLowOut  = 1'b0;
        bus.ZHighOut = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.opcode   = '0;
        bus.done     = 1'b0;
        bus.illegal  = 1'b0;
        rin_en       = 1'b0;
        rout_en      = 1'b0;
        rout_sel     = ir_q.rb;
`ifdef SINGLE_STEP_EN
        after_done   = bus.run ? S_PAUSE : S_IDLE;
`else
        after_done   = bus.run ? S_T0 : S_IDLE;
`endif

        case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.incPC = 1'b1;
                state_d   = S_T1;
            end
            S_T1: begin
                bus.read  = 1'b1;
                bus.MDRin = 1'b1;
                bus.PCin  = 1'b1;
                if (bus.mem_ready) state_d = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = S_T3;
            end
            S_T3: begin
                rout_en  = 1'b1;
                rout_sel = ir_now.rb;
                bus.Yin  = 1'b1;
                if (!is_legal(ir_now.op))    state_d = S_HALT;
                else if (is_unary(ir_now.op)) state_d = S_T4U;
                else                          state_d = S_T4;
            end
            S_T4, S_T4U: begin
                rout_en    = 1'b1;
                rout_sel   = (state_q == S_T4U) ? ir_q.rb : ir_q.rc;
                bus.opcode = ir_q.op;
                bus.Zin    = 1'b1;
                state_d    = S_T5;
            end
            S_T5: begin
                bus.ZLowOut = 1'b1;
                if (is_muldiv(ir_q.op)) begin
                    bus.LOin = 1'b1;
                    state_d  = S_T6;
                end else begin
                    rin_en   = 1'b1;
                    bus.done = 1'b1;
                    state_d  = after_done;
                end
            end
            S_T6: begin
                bus.ZHighOut = 1'b1;
                bus.HIin     = 1'b1;
                bus.done     = 1'b1;
                state_d      = after_done;
            end
            S_HALT: bus.illegal = 1'b1;
`ifdef SINGLE_STEP_EN
            S_PAUSE: if (bus.run && bus.step) state_d = S_T0;
`endif
            default: state_d = S_IDLE;
        endcase

        bus.busy = (state_q != S_IDLE) && (state_q != S_HALT)
`ifdef SINGLE_STEP_EN
                   && (state_q != S_PAUSE)
`endif
                   ;
    end

    reg_select_decoder #(.WIDTH(NUM_REGS)) u_rin_dec (
        .sel    (ir_q.ra),
        .en     (rin_en),
        .onehot (rin_vec)
    );

    reg_select_decoder #(.WIDTH(NUM_REGS)) u_rout_dec (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (rout_vec)
    );

    assign bus.Rin  = rin_vec;
    assign bus.Rout = rout_vec;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench: behavioural datapath plus per-cycle expected strobe table per instruction.
module tb_alu_instr_sequencer;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    alu_instr_sequencer_if bus ();

    alu_instr_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        pcout, marin, incpc, pcin, rd, mdrin, mdrout, irin;
        logic        yin, zin, zlowout, zhighout, hiin, loin;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  opc;
        logic        busy, done, illegal;
    } obs_t;

    typedef enum {PH_IDLE, PH_FETCH_ADDR, PH_FETCH_WAIT, PH_IRLOAD, PH_DECODE,
                  PH_OPA, PH_UNARY, PH_WB, PH_HI, PH_HALT} phase_t;

    localparam logic [4:0] LEGAL_OPS [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
        5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010};

    // ---------------- behavioural datapath ----------------
    logic [31:0] R [16];
    logic [31:0] MDR, IRm, Y, HI, LO, pc, fetch_word, dbv;
    logic [63:0] Z;
    logic        ld_en;
    logic [3:0]  ld_idx;
    logic [31:0] ld_val;

    function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b);
        logic [63:0]        t;
        logic signed [63:0] p;
        logic [4:0]         s;
        s = b[4:0];
        case (op)
            5'b00011: return {32'b0, y + b};
            5'b00100: return {32'b0, y - b};
            5'b00101: return {32'b0, y & b};
            5'b00110: return {32'b0, y | b};
            5'b00111: begin t = {y, y} >> s; return {32'b0, t[31:0]}; end
            5'b01000: begin t = {y, y} << s; return {32'b0, t[63:32]}; end
            5'b01001: return {32'b0, y >> s};
            5'b01010: return {32'b0, $unsigned($signed(y) >>> s)};
            5'b01011: return {32'b0, y << s};
            5'b01111: begin p = $signed(y) * $signed(b); return p; end
            5'b10000: return {y % b, y / b};
            5'b10001: return {32'b0, 32'd0 - b};
            5'b10010: return {32'b0, ~b};
            default:  return 64'd0;
        endcase
    endfunction

    always_comb begin
        dbv = '0;
        if (bus.PCout)    dbv = pc;
        if (bus.MDRout)   dbv = MDR;
        if (bus.ZLowOut)  dbv = Z[31:0];
        if (bus.ZHighOut) dbv = Z[63:32];
        for (int i = 0; i < 16; i++) if (bus.Rout[i]) dbv = R[i];
    end

    assign bus.ir = IRm;

    always @(posedge clock) begin
        if (!clear) begin
            MDR <= '0; IRm <= '0; Y <= '0; Z <= '0; HI <= '0; LO <= '0; pc <= '0;
        end else begin
            if (bus.incPC) pc <= pc + 32'd1;
            if (bus.MDRin && bus.read && bus.mem_ready) MDR <= fetch_word;
            if (bus.IRin) IRm <= dbv;
            if (bus.Yin)  Y <= dbv;
            if (bus.Zin)  Z <= alu(bus.opcode, Y, dbv);
            if (bus.LOin) LO <= dbv;
            if (bus.HIin) HI <= dbv;
        end
        if (ld_en) R[ld_idx] <= ld_val;
        for (int i = 0; i < 16; i++) if (bus.Rin[i]) R[i] <= dbv;
    end

    // ---------------- reference expectations ----------------
    function automatic bit op_legal(input logic [4:0] op);
        foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit op_unary(input logic [4:0] op);
        return (op == 5'b10001) || (op == 5'b10010);
    endfunction

    function automatic bit op_muldiv(input logic [4:0] op);
        return (op == 5'b01111) || (op == 5'b10000);
    endfunction

    function automatic obs_t expect_phase(input phase_t p, input logic [31:0] instr);
        obs_t e = '0;
        logic [4:0] op = instr[31:27];
        logic [3:0] ra = instr[26:23];
        logic [3:0] rb = instr[22:19];
        logic [3:0] rc = instr[18:15];
        e.busy = !(p inside {PH_IDLE, PH_HALT});
        case (p)
            PH_FETCH_ADDR: begin e.pcout = 1; e.marin = 1; e.incpc = 1; end
            PH_FETCH_WAIT: begin e.rd = 1; e.mdrin = 1; e.pcin = 1; end
            PH_IRLOAD:     begin e.mdrout = 1; e.irin = 1; end
            PH_DECODE:     begin e.rout = 16'd1 << rb; e.yin = 1; end
            PH_OPA:        begin e.rout = 16'd1 << rc; e.opc = op; e.zin = 1; end
            PH_UNARY:      begin e.rout = 16'd1 << rb; e.opc = op; e.zin = 1; end
            PH_WB: begin
                e.zlowout = 1;
                if (op_muldiv(op)) e.loin = 1;
                else begin e.rin = 16'd1 << ra; e.done = 1; end
            end
            PH_HI:   begin e.zhighout = 1; e.hiin = 1; e.done = 1; end
            PH_HALT: e.illegal = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.pcout = bus.PCout;  o.marin = bus.MARin;   o.incpc = bus.incPC;   o.pcin = bus.PCin;
        o.rd = bus.read;      o.mdrin = bus.MDRin;   o.mdrout = bus.MDRout; o.irin = bus.IRin;
        o.yin = bus.Yin;      o.zin = bus.Zin;       o.zlowout = bus.ZLowOut;
        o.zhighout = bus.ZHighOut; o.hiin = bus.HIin; o.loin = bus.LOin;
        o.rin = bus.Rin;      o.rout = bus.Rout;     o.opc = bus.opcode;
        o.busy = bus.busy;    o.done = bus.done;     o.illegal = bus.illegal;
        return o;
    endfunction

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h", tag, got, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_reg(input int idx, input logic [31:0] val);
        ld_en = 1'b1; ld_idx = 4'(idx); ld_val = val;
        @(posedge clock); #1;
        ld_en = 1'b0;
    endtask

    task automatic go_from_idle();
        bus.run = 1'b1;
        @(negedge clock);
        check_obs("idle_before_start", observe(), '0);
        @(posedge clock); #1;
    endtask

    // Entered #1 after the edge that put the sequencer in T0; leaves #1 after the edge following the last phase.
    task automatic run_instr(input logic [31:0] instr, input int stall, input bit run_level, input bit abort_exec);
        phase_t     ph[$];
        logic [4:0] op = instr[31:27];
        fetch_word = instr;
        ph.push_back(PH_FETCH_ADDR);
        repeat (stall + 1) ph.push_back(PH_FETCH_WAIT);
        ph.push_back(PH_IRLOAD);
        ph.push_back(PH_DECODE);
        if (!op_legal(op)) ph.push_back(PH_HALT);
        else begin
            ph.push_back(op_unary(op) ? PH_UNARY : PH_OPA);
            ph.push_back(PH_WB);
            if (op_muldiv(op)) ph.push_back(PH_HI);
        end
        foreach (ph[k]) begin
            bus.mem_ready = (ph[k] == PH_FETCH_WAIT) && (k == stall + 1);
            if (k >= 2) bus.run = run_level;
            @(negedge clock);
            check_obs(ph[k].name(), observe(), expect_phase(ph[k], instr));
            if (abort_exec && (ph[k] inside {PH_OPA, PH_UNARY})) begin
                #2 clear = 1'b0;
                #1 check_obs("async_clear_mid_exec", observe(), '0);
                @(posedge clock); #1;
                clear = 1'b1;
                bus.run = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
        bus.mem_ready = 1'b0;
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input int ra, input int rb, input int rc);
        return {op, 4'(ra), 4'(rb), 4'(rc), 15'd0};
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [63:0] expz;
        logic [31:0] a, b, instr;
        logic [4:0]  op;
        int          ra, rb, rc;
        bit          run_level, in_t0;

        clear = 1'b0; bus.run = 1'b0; bus.mem_ready = 1'b0;
        ld_en = 1'b0; ld_idx = '0; ld_val = '0; fetch_word = '0;
        for (int i = 0; i < 16; i++) begin
            ld_en = 1'b1; ld_idx = 4'(i); ld_val = '0;
            @(posedge clock); #1;
        end
        ld_en = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check_obs("reset_hold", observe(), '0);
        end
        bus.run = 1'b1;
        @(negedge clock);
        check_obs("reset_hold_run_high", observe(), '0);
        @(posedge clock); #1;
        bus.run = 1'b0;
        clear = 1'b1;

        // SHRA R4,R3,R7
        set_reg(3, 32'hFFFF_FFF6); set_reg(7, 32'd2);
        go_from_idle();
        run_instr(32'h521B_8000, 0, 1'b0, 1'b0);
        check_word("shra_r4", R[4], 32'hFFFF_FFFD);

        // ADD with a 3-cycle memory stall, then NOT R2,R1 back-to-back with run held
        set_reg(9, 32'd5); set_reg(10, 32'd9); set_reg(1, 32'h0000_FFFF);
        go_from_idle();
        run_instr(enc(5'b00011, 8, 9, 10), 3, 1'b1, 1'b0);
        check_word("add_stall_r8", R[8], 32'd14);
        run_instr(enc(5'b10010, 2, 1, 0), 0, 1'b0, 1'b0);
        check_word("not_r2", R[2], 32'hFFFF_0000);

        // MUL R0,R5,R6
        set_reg(5, 32'd6); set_reg(6, 32'd7); set_reg(0, 32'h1234_5678);
        go_from_idle();
        run_instr(enc(5'b01111, 0, 5, 6), 0, 1'b0, 1'b0);
        check_word("mul_lo", LO, 32'd42);
        check_word("mul_hi", HI, 32'd0);
        check_word("mul_r0_untouched", R[0], 32'h1234_5678);

        // clear asserted mid-T4 of an ADD: no writeback may happen
        set_reg(11, 32'h0000_AAAA); set_reg(12, 32'd1); set_reg(13, 32'd2);
        go_from_idle();
        run_instr(enc(5'b00011, 11, 12, 13), 1, 1'b1, 1'b1);
        check_word("aborted_add_r11", R[11], 32'h0000_AAAA);

        // randomized legal instructions
        in_t0 = 1'b0;
        for (int n = 0; n < 24; n++) begin
            op = LEGAL_OPS[$urandom_range(0, 12)];
            ra = $urandom_range(0, 15); rb = $urandom_range(0, 15); rc = $urandom_range(0, 15);
            if (!in_t0) begin
                set_reg(rb, $urandom);
                set_reg(rc, $urandom);
            end
            a = R[rb];
            b = op_unary(op) ? R[rb] : R[rc];
            if (op == 5'b10000 && b == 32'd0) op = 5'b00011;
            expz = alu(op, a, b);
            run_level = (n == 23) ? 1'b0 : ($urandom_range(0, 3) != 0);
            instr = enc(op, ra, rb, rc);
            if (!in_t0) go_from_idle();
            run_instr(instr, $urandom_range(0, 3), run_level, 1'b0);
            if (op_muldiv(op)) begin
                check_word("rand_lo", LO, expz[31:0]);
                check_word("rand_hi", HI, expz[63:32]);
            end else begin
                check_word("rand_rd", R[ra], expz[31:0]);
            end
            in_t0 = run_level;
        end

        // illegal opcode: HALT, sticky, ignores run until clear
        go_from_idle();
        run_instr(enc(5'b11111, 1, 2, 3), 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.run = i[0];
            @(negedge clock);
            check_obs("halt_sticky", observe(), expect_phase(PH_HALT, 32'd0));
            @(posedge clock); #1;
        end
        clear = 1'b0;
        #1 check_obs("halt_cleared", observe(), '0);
        bus.run = 1'b0;
        @(posedge clock); #1;
        clear = 1'b1;
        @(negedge clock);
        check_obs("idle_after_halt", observe(), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
